// File: rtl/cmos_nor.sv
// cmos_nor: WIDTH-bit bitwise 2-input NOR built from CMOS switch primitives,
// plus a registered copy of the result with a valid flag.
//
// Ports:
//   clk        rising-edge clock for the registered path
//   rst_n      asynchronous active-low reset (clears f_q, out_valid, counter)
//   x, y       operands; bit i drives slice i
//   in_valid   qualifies x/y for capture into f_q
//   f          combinational NOR straight from the switch network
//   f_q        registered NOR result (holds when in_valid is low)
//   out_valid  f_q was captured from a valid input on the last edge
//   toggle_cnt (only with CMOS_NOR_TOGGLE_CNT_EN) saturating count of valid
//              captures that changed f_q
//
// Optional feature macro: CMOS_NOR_TOGGLE_CNT_EN
module cmos_nor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_q,
  output logic             out_valid
`ifdef CMOS_NOR_TOGGLE_CNT_EN
  ,
  output logic [15:0]      toggle_cnt
`endif
);

  supply1 vdd;
  supply0 gnd;

  wire [WIDTH-1:0] pu_mid;
  wire [WIDTH-1:0] f_net;

  // Each slice is a textbook 4-transistor NOR: series pull-up, parallel
  // pull-down. No delays, so f settles within the same timestep.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_slice
      pmos p_x (pu_mid[i], vdd, x[i]);
      pmos p_y (f_net[i], pu_mid[i], y[i]);
      nmos n_x (f_net[i], gnd, x[i]);
      nmos n_y (f_net[i], gnd, y[i]);
    end
  endgenerate

  // Whatever the switches resolve (including X) is passed through untouched.
  assign f = f_net;

  logic [WIDTH-1:0] cap_d, cap_q;
  logic             valid_d, valid_q;

  always_comb begin
    cap_d   = cap_q;
    valid_d = 1'b0;
    if (in_valid) begin
      cap_d   = f;
      valid_d = 1'b1;
    end
  end

`ifdef CMOS_NOR_TOGGLE_CNT_EN
  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    // Only valid captures that change at least one bit count; stick at max.
    if (in_valid && (cap_d != cap_q) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      valid_q <= valid_d;
    end
  end

  assign f_q       = cap_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cmos_nor.sv
module tb_cmos_nor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       x1 = 1'b0, y1 = 1'b0;
  logic [3:0] x4 = 4'd0, y4 = 4'd0;

  logic       f1, fq1, ov1;
  logic [3:0] f4, fq4;
  logic       ov4;
`ifdef CMOS_NOR_TOGGLE_CNT_EN
  logic [15:0] tog1, tog4;
`endif

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cmos_nor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .in_valid(in_valid),
    .f(f1), .f_q(fq1), .out_valid(ov1)
`ifdef CMOS_NOR_TOGGLE_CNT_EN
    , .toggle_cnt(tog1)
`endif
  );

  cmos_nor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .in_valid(in_valid),
    .f(f4), .f_q(fq4), .out_valid(ov4)
`ifdef CMOS_NOR_TOGGLE_CNT_EN
    , .toggle_cnt(tog4)
`endif
  );

  // Reference: a bit is 1 exactly when neither operand bit is set.
  function automatic logic [3:0] nor_ref(input logic [3:0] a, input logic [3:0] b, input int w);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < w; k++) r[k] = (a[k] == 1'b0 && b[k] == 1'b0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the registered path.
  logic [0:0] m_fq1;
  logic [3:0] m_fq4;
  logic       m_ov;
  int         m_tog1, m_tog4;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] n1, n4;
    if (!rst_n) begin
      m_fq1 = 1'b0; m_fq4 = 4'd0; m_ov = 1'b0; m_tog1 = 0; m_tog4 = 0;
    end else if (in_valid) begin
      n1 = nor_ref({3'b0, x1}, {3'b0, y1}, 1);
      n4 = nor_ref(x4, y4, 4);
      if (n1[0] != m_fq1[0] && m_tog1 < 65535) m_tog1++;
      if (n4 != m_fq4 && m_tog4 < 65535) m_tog4++;
      m_fq1 = n1[0:0];
      m_fq4 = n4;
      m_ov  = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e1, e4;
    if (cmp_en) begin
      e1 = nor_ref({3'b0, x1}, {3'b0, y1}, 1);
      e4 = nor_ref(x4, y4, 4);
      check("f1_comb", {31'b0, f1}, {31'b0, e1[0]});
      check("f4_comb", {28'b0, f4}, {28'b0, e4});
      check("fq1", {31'b0, fq1}, {31'b0, m_fq1});
      check("fq4", {28'b0, fq4}, {28'b0, m_fq4});
      check("ov1", {31'b0, ov1}, {31'b0, m_ov});
      check("ov4", {31'b0, ov4}, {31'b0, m_ov});
`ifdef CMOS_NOR_TOGGLE_CNT_EN
      check("tog1", {16'b0, tog1}, m_tog1);
      check("tog4", {16'b0, tog4}, m_tog4);
`endif
    end
  end

  initial begin
    logic [2:0] v;
    logic [1:0] xy;
    logic [4:0] sweep_exp;
    sweep_exp = 5'b10001; // f for {x,y} = 4,3,2,1,0 (msb..lsb)

    // Reset held: combinational sweep including the wrap value 4.
    #1 cmp_en = 1'b1;
    for (int s = 0; s < 5; s++) begin
      v = s[2:0];
      xy = v[1:0];
      {x1, y1} = xy;
      #1;
      check("sweep_f", {31'b0, f1}, {31'b0, sweep_exp[s]});
      check("sweep_fq", {30'b0, fq1, ov1}, 32'd0);
      #104;
    end

    // Release, then 00 and 11 back to back.
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2 x1 = 1'b0; y1 = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 check("fq_00", {30'b0, fq1, ov1}, 32'd3);
    #1 x1 = 1'b1; y1 = 1'b1;
    @(posedge clk); #1 check("fq_11", {30'b0, fq1, ov1}, 32'd1);
    #1 x1 = 1'b0; y1 = 1'b1;
    @(posedge clk); #1 check("fq_01", {30'b0, fq1, ov1}, 32'd1);
    #1 x1 = 1'b0; y1 = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 check("hold_fq", {30'b0, fq1, ov1}, 32'd0);
    check("hold_f", {31'b0, f1}, 32'd1);

    // Asynchronous reset between edges.
    #1 in_valid = 1'b1;
    @(posedge clk); #1 check("pre_rst", {30'b0, fq1, ov1}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {30'b0, fq1, ov1}, 32'd0);
    #1 rst_n = 1'b1; in_valid = 1'b0;

    // WIDTH=4 vector.
    @(posedge clk); #2 x4 = 4'b1010; y4 = 4'b0110; in_valid = 1'b1;
    #1 check("w4_f", {28'b0, f4}, 32'h1);
    @(posedge clk); #1 check("w4_fq", {27'b0, ov4, fq4}, 32'h11);
    #1 in_valid = 1'b0;

    // Toggle counter: 10 alternating captures starting from a fresh reset.
    @(posedge clk); #2 rst_n = 1'b0; #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2 in_valid = 1'b1;
      {x1, y1} = (c % 2 == 0) ? 2'b11 : 2'b00;
    end
    @(posedge clk); #1;
`ifdef CMOS_NOR_TOGGLE_CNT_EN
    check("tog_9", {16'b0, tog1}, 32'd9);
`endif
    check("tog_last_fq", {31'b0, fq1}, 32'd1);
    #1 in_valid = 1'b0;

    // Randomized run with occasional asynchronous resets.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      x1 = 1'($urandom); y1 = 1'($urandom);
      x4 = 4'($urandom); y4 = 4'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) begin
        #1 rst_n = 1'b0;
        #1 check("rnd_rst", {27'b0, ov1, ov4, fq1, fq4[1:0]}, 32'd0);
        rst_n = 1'b1;
      end
    end

    @(posedge clk); #2 cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
